dma_channel_scheduler: RTL and testbench

DMA_CHANNEL_SCHEDULER -- requirements
Module: dma_channel_scheduler

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_prio_arbiter.sv | 36 +++
 rtl/dma_channel_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel scheduler.
// The state enum and the channel-index width are used by the top and the arbiter.
package dma_pkg;

  localparam int DMA_NUM_CH = 4;
  localparam int DMA_AW     = 16;
  localparam int CH_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_XFER,
    ST_DONE
  } state_t;

  function automatic logic [DMA_NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return DMA_NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_prio_arbiter.sv
// Combinational channel arbiter: fixed priority (ch0 highest) or rotating
// priority starting at ptr. Picks the first eligible channel in priority order.
module dma_prio_arbiter
  import dma_pkg::*;
(
  input  logic [DMA_NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]       ptr,
  input  logic                  rotate_en,
  output logic [CH_W-1:0]       winner,
  output logic                  valid
);

  logic [CH_W-1:0]       base;
  logic [DMA_NUM_CH-1:0] rot;
  logic [CH_W-1:0]       offset;

  assign base = rotate_en ? ptr : '0;

  // rot[0] is the highest-priority channel for this cycle.
  generate
    for (genvar gi = 0; gi < DMA_NUM_CH; gi++) begin : g_rot
      assign rot[gi] = eligible[base + CH_W'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = DMA_NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) offset = CH_W'(i);
    end
  end

  assign valid  = |rot;
  assign winner = base + offset;

endmodule

// File: rtl/dma_channel_scheduler.sv
// Four-channel DMA scheduler: arbitrates requests, handshakes the bus with
// hrq/hlda, then streams block-mode address beats with registered outputs.
module dma_channel_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int AW     = DMA_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              rotate_en,
  input  logic              hlda,
  input  logic [AW-1:0]     base_address_in,
  input  logic [AW-1:0]     base_word_in,
  input  logic [NUM_CH-1:0] tc_clear,
  output logic [CH_W-1:0]   ch_select,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic              xfer_valid,
  output logic [AW-1:0]     addr_out,
  output logic              eop,
  output logic [NUM_CH-1:0] tc_status
);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_select_reg, ch_select_next;
  logic              hrq_reg, hrq_next;
  logic [NUM_CH-1:0] dack_reg, dack_next;
  logic              xfer_valid_reg, xfer_valid_next;
  logic [AW-1:0]     addr_out_reg, addr_out_next;
  logic              eop_reg, eop_next;
  logic [NUM_CH-1:0] tc_status_reg, tc_status_next;
  logic [CH_W-1:0]   prio_ptr_reg, prio_ptr_next;
  logic [AW-1:0]     cur_addr_reg, cur_addr_next;
  logic [AW-1:0]     cur_cnt_reg, cur_cnt_next;

  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   arb_winner;
  logic              arb_valid;
  logic              go_done;
  logic              go_abort;

  assign eligible = dreq & ~ch_mask & ~tc_status_reg;

  dma_prio_arbiter u_arbiter (
    .eligible  (eligible),
    .ptr       (prio_ptr_reg),
    .rotate_en (rotate_en),
    .winner    (arb_winner),
    .valid     (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      ch_select_reg  <= '0;
      hrq_reg        <= 1'b0;
      dack_reg       <= '0;
      xfer_valid_reg <= 1'b0;
      addr_out_reg   <= '0;
      eop_reg        <= 1'b0;
      tc_status_reg  <= '0;
      prio_ptr_reg   <= '0;
      cur_addr_reg   <= '0;
      cur_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      ch_select_reg  <= ch_select_next;
      hrq_reg        <= hrq_next;
      dack_reg       <= dack_next;
      xfer_valid_reg <= xfer_valid_next;
      addr_out_reg   <= addr_out_next;
      eop_reg        <= eop_next;
      tc_status_reg  <= tc_status_next;
      prio_ptr_reg   <= prio_ptr_next;
      cur_addr_reg   <= cur_addr_next;
      cur_cnt_reg    <= cur_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ch_select_next  = ch_select_reg;
    hrq_next        = hrq_reg;
    dack_next       = dack_reg;
    xfer_valid_next = xfer_valid_reg;
    addr_out_next   = addr_out_reg;
    eop_next        = 1'b0;
    tc_status_next  = tc_status_reg & ~tc_clear;
    prio_ptr_next   = prio_ptr_reg;
    cur_addr_next   = cur_addr_reg;
    cur_cnt_next    = cur_cnt_reg;
    go_done         = 1'b0;
    go_abort        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        hrq_next        = 1'b0;
        dack_next       = '0;
        xfer_valid_next = 1'b0;
        if (arb_valid) begin
          ch_select_next = arb_winner;
          hrq_next       = 1'b1;
          state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hlda) begin
          dack_next  = ch_onehot(ch_select_reg);
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!hlda) begin
          go_abort = 1'b1;
        end else begin
          cur_addr_next = base_address_in;
          cur_cnt_next  = base_word_in;
          if (base_word_in != '0) begin
            xfer_valid_next = 1'b1;
            addr_out_next   = base_address_in;
            state_next      = ST_XFER;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      ST_XFER: begin
        // cur_addr/cur_cnt describe the beat currently on addr_out.
        if (!hlda) begin
          go_abort = 1'b1;
        end else if (cur_cnt_reg == AW'(1)) begin
          go_done = 1'b1;
        end else begin
          cur_addr_next = cur_addr_reg + AW'(1);
          addr_out_next = cur_addr_reg + AW'(1);
          cur_cnt_next  = cur_cnt_reg - AW'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (go_abort) begin
      state_next      = ST_IDLE;
      hrq_next        = 1'b0;
      dack_next       = '0;
      xfer_valid_next = 1'b0;
    end

    // Setting the terminal-count bit overrides a simultaneous clear.
    if (go_done) begin
      state_next                    = ST_DONE;
      eop_next                      = 1'b1;
      tc_status_next[ch_select_reg] = 1'b1;
      hrq_next                      = 1'b0;
      dack_next                     = '0;
      xfer_valid_next               = 1'b0;
      prio_ptr_next                 = ch_select_reg + CH_W'(1);
    end
  end

  assign ch_select  = ch_select_reg;
  assign hrq        = hrq_reg;
  assign dack       = dack_reg;
  assign xfer_valid = xfer_valid_reg;
  assign addr_out   = addr_out_reg;
  assign eop        = eop_reg;
  assign tc_status  = tc_status_reg;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scoreboard bench for dma_channel_scheduler: stimulus pushes expected
// grant/beat/eop events, a negedge monitor pops and compares them.
module tb_dma_channel_scheduler;

  localparam int EV_GRANT = 0;
  localparam int EV_BEAT  = 1;
  localparam int EV_EOP   = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dreq;
  logic [3:0]  ch_mask;
  logic        rotate_en;
  logic        hlda;
  logic [15:0] base_address_in;
  logic [15:0] base_word_in;
  logic [3:0]  tc_clear;
  logic [1:0]  ch_select;
  logic        hrq;
  logic [3:0]  dack;
  logic        xfer_valid;
  logic [15:0] addr_out;
  logic        eop;
  logic [3:0]  tc_status;

  logic [15:0] addr_tab [4];
  logic [15:0] word_tab [4];

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  grant_cnt = 0;
  int  eop_cnt = 0;
  int  hlda_rise_cyc = 0;
  int  hlda_delay = 0;
  int  clr_mode = 0;
  int  abort_after = 0;
  logic clr_all_req = 1'b0;

  dma_channel_scheduler #(.NUM_CH(4), .AW(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dreq            (dreq),
    .ch_mask         (ch_mask),
    .rotate_en       (rotate_en),
    .hlda            (hlda),
    .base_address_in (base_address_in),
    .base_word_in    (base_word_in),
    .tc_clear        (tc_clear),
    .ch_select       (ch_select),
    .hrq             (hrq),
    .dack            (dack),
    .xfer_valid      (xfer_valid),
    .addr_out        (addr_out),
    .eop             (eop),
    .tc_status       (tc_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Base-register buffer: addressed by ch_select.
  always_comb begin
    base_address_in = addr_tab[ch_select];
    base_word_in    = word_tab[ch_select];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_xfer(input int ch, input logic [15:0] addr, input int n);
    logic [15:0] a;
    push(EV_GRANT, 32'(4'(1) << ch));
    a = addr;
    for (int i = 0; i < n; i++) begin
      push(EV_BEAT, 32'(a));
      a = a + 16'd1;
    end
    push(EV_EOP, 32'(ch));
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got 0x%0h expected no event (t=%0t)", name, val, $time);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 32'(kind), 32'(e.kind));
      chk({name, "_val"}, val, e.val);
    end
  endtask

  // Monitor
  initial begin
    logic [3:0] prev_dack;
    logic       first_beat;
    prev_dack  = '0;
    first_beat = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_dack  = '0;
        first_beat = 1'b0;
      end else begin
        if (dack != 4'd0 && prev_dack == 4'd0) begin
          grant_cnt++;
          first_beat = 1'b1;
          expect_ev(EV_GRANT, 32'(dack), "grant");
          $display("grant dack=%b ch_select=%0d", dack, ch_select);
        end
        if (xfer_valid) begin
          expect_ev(EV_BEAT, 32'(addr_out), "beat");
          $display("beat addr=%04h", addr_out);
          if (first_beat) chk("hlda_to_beat", 32'(cyc - hlda_rise_cyc), 32'd2);
          first_beat = 1'b0;
        end
        if (eop) begin
          eop_cnt++;
          expect_ev(EV_EOP, 32'(ch_select), "eop");
          $display("eop ch=%0d tc_status=%b", ch_select, tc_status);
        end
        prev_dack = dack;
      end
    end
  end

  // CPU / tc-clear model driving hlda and tc_clear
  initial begin
    int         wait_cnt;
    int         beat_cnt;
    logic [3:0] cpu_prev_dack;
    hlda          = 1'b0;
    tc_clear      = '0;
    wait_cnt      = 0;
    beat_cnt      = 0;
    cpu_prev_dack = '0;
    forever begin
      @(posedge clk);
      #1;
      tc_clear = '0;
      if (!rst_n) begin
        hlda     = 1'b0;
        wait_cnt = 0;
        beat_cnt = 0;
      end else begin
        if (clr_all_req) begin
          tc_clear    = 4'hF;
          clr_all_req = 1'b0;
        end
        if (clr_mode == 1 && eop) tc_clear = 4'(1) << ch_select;
        if (clr_mode == 2 && dack != 4'd0 && cpu_prev_dack == 4'd0) tc_clear = dack;
        if (xfer_valid) beat_cnt++;
        if (!hrq) begin
          hlda     = 1'b0;
          wait_cnt = 0;
          beat_cnt = 0;
        end else if (abort_after != 0 && beat_cnt >= abort_after) begin
          hlda = 1'b0;
        end else if (!hlda) begin
          if (wait_cnt >= hlda_delay) begin
            hlda          = 1'b1;
            hlda_rise_cyc = cyc;
          end else begin
            wait_cnt++;
          end
        end
      end
      cpu_prev_dack = dack;
    end
  end

  task automatic wait_grants(input int target, input string name);
    int n = 0;
    while (grant_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_grant_reached"}, 32'(grant_cnt >= target), 32'd1);
  endtask

  task automatic wait_eops(input int target, input string name);
    int n = 0;
    while (eop_cnt < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_eop_reached"}, 32'(eop_cnt >= target), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_all_tc();
    clr_all_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ch_select, hrq, dack, xfer_valid, addr_out, eop, tc_status});
  endfunction

  initial begin
    int e0;
    int g0;
    rst_n     = 1'b0;
    dreq      = '0;
    ch_mask   = '0;
    rotate_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_tab[i] = 16'h0;
      word_tab[i] = 16'h0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 32'd0);

    // ch0, 10 words from 0x0064, hlda after 3 cycles
    addr_tab[0] = 16'h0064;
    word_tab[0] = 16'd10;
    hlda_delay  = 3;
    push_xfer(0, 16'h0064, 10);
    e0 = eop_cnt;
    g0 = grant_cnt;
    @(posedge clk); #1;
    dreq = 4'b0001;
    chk("hrq_before", 32'(hrq), 32'd0);
    @(posedge clk); #1;
    chk("hrq_latency", 32'(hrq), 32'd1);
    wait_grants(g0 + 1, "ch0");
    dreq = 4'b0000;
    wait_eops(e0 + 1, "ch0");
    @(negedge clk);
    chk("ch0_tc_status", 32'(tc_status), 32'h1);
    wait_drain("ch0");
    clear_all_tc();
    chk("tc_cleared", 32'(tc_status), 32'h0);

    // Fixed priority, dreq=1010: ch1 first, then ch3
    hlda_delay  = 0;
    clr_mode    = 1;
    addr_tab[1] = 16'h1000; word_tab[1] = 16'd2;
    addr_tab[3] = 16'h3000; word_tab[3] = 16'd3;
    push_xfer(1, 16'h1000, 2);
    push_xfer(3, 16'h3000, 3);
    e0 = eop_cnt;
    g0 = grant_cnt;
    dreq = 4'b1010;
    wait_grants(g0 + 1, "fixed_first");
    dreq = 4'b1000;
    wait_grants(g0 + 2, "fixed_second");
    dreq = 4'b0000;
    wait_eops(e0 + 2, "fixed");
    @(negedge clk);
    chk("fixed_tc_status", 32'(tc_status), 32'h0);
    wait_drain("fixed");

    // Rotating priority: grant order 0,1,2,3,0
    rotate_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      addr_tab[c] = 16'h0A00 + 16'(c * 16);
      word_tab[c] = 16'd1;
    end
    push_xfer(0, 16'h0A00, 1);
    push_xfer(1, 16'h0A10, 1);
    push_xfer(2, 16'h0A20, 1);
    push_xfer(3, 16'h0A30, 1);
    push_xfer(0, 16'h0A00, 1);
    e0 = eop_cnt;
    g0 = grant_cnt;
    dreq = 4'b1111;
    wait_grants(g0 + 5, "rotate");
    dreq = 4'b0000;
    wait_eops(e0 + 5, "rotate");
    wait_drain("rotate");
    @(negedge clk);
    chk("rotate_tc_status", 32'(tc_status), 32'h0);
    rotate_en = 1'b0;
    clr_mode  = 0;

    // Address wrap FFFE, FFFF, 0000
    addr_tab[0] = 16'hFFFE;
    word_tab[0] = 16'd3;
    push_xfer(0, 16'hFFFE, 3);
    e0 = eop_cnt;
    g0 = grant_cnt;
    dreq = 4'b0001;
    wait_grants(g0 + 1, "wrap");
    dreq = 4'b0000;
    wait_eops(e0 + 1, "wrap");
    @(negedge clk);
    chk("wrap_tc_status", 32'(tc_status), 32'h1);
    wait_drain("wrap");
    clear_all_tc();

    // hlda dropped after the 2nd beat: abort, no eop, tc stays 0
    abort_after = 2;
    addr_tab[1] = 16'h0200;
    word_tab[1] = 16'd5;
    push(EV_GRANT, 32'h2);
    push(EV_BEAT, 32'h0200);
    push(EV_BEAT, 32'h0201);
    e0 = eop_cnt;
    g0 = grant_cnt;
    dreq = 4'b0010;
    wait_grants(g0 + 1, "abort");
    dreq = 4'b0000;
    wait_drain("abort");
    @(negedge clk);
    chk("abort_xfer_valid", 32'(xfer_valid), 32'd0);
    chk("abort_hrq_dack", 32'({hrq, dack}), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_eop", 32'(eop_cnt), 32'(e0));
    chk("abort_tc_status", 32'(tc_status), 32'h0);
    abort_after = 0;

    // Zero-word transfer on ch2 with tc_clear colliding with the set
    clr_mode    = 2;
    addr_tab[2] = 16'h0400;
    word_tab[2] = 16'd0;
    push(EV_GRANT, 32'h4);
    push(EV_EOP, 32'd2);
    e0 = eop_cnt;
    g0 = grant_cnt;
    dreq = 4'b0100;
    wait_grants(g0 + 1, "zero");
    dreq = 4'b0000;
    wait_eops(e0 + 1, "zero");
    @(negedge clk);
    chk("zero_tc_set_wins", 32'(tc_status), 32'h4);
    wait_drain("zero");
    clr_mode = 0;
    clear_all_tc();

    // Reset mid-XFER on ch3, then first arbitration right after release
    addr_tab[3] = 16'h0300;
    word_tab[3] = 16'd8;
    push_xfer(3, 16'h0300, 8);
    g0 = grant_cnt;
    dreq = 4'b1000;
    wait_grants(g0 + 1, "rst");
    dreq = 4'b0000;
    begin
      int n = 0;
      while (exp_q.size() > 6 && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("rst_mid_xfer_active", 32'(xfer_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 32'd0);
    exp_q.delete();
    e0 = eop_cnt;
    addr_tab[0] = 16'h0500;
    word_tab[0] = 16'd1;
    dreq = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held_outputs", all_outs(), 32'd0);
    chk("rst_no_eop", 32'(eop_cnt), 32'(e0));
    push_xfer(0, 16'h0500, 1);
    g0 = grant_cnt;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_arb_after_rst", 32'(hrq), 32'd1);
    wait_grants(g0 + 1, "post_rst");
    dreq = 4'b0000;
    wait_eops(e0 + 1, "post_rst");
    wait_drain("post_rst");
    chk("post_rst_eop_count", 32'(eop_cnt), 32'(e0 + 1));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
